pos_counter_bounded: RTL and testbench
======================================

Name: pos_counter_bounded

Overview:
Parametrised position counter. It is the successor to the fixed 11-bit up/down position register used for sprite and cannon placement. It adds configurable width, reset value, bounds, step size and a move-rate prescaler, plus a saturating/wrap mode, a synchronous load and status flags. It sits between the input-decoding logic (keys or mouse) and the VGA object renderer, and is instantiated once per movable axis.

Parameters:
- WIDTH, 11, bit width of count
- RESET_VAL, 228, value of count after reset; must lie within [MIN_VAL, MAX_VAL]
- MIN_VAL, 0, lower bound of count
- MAX_VAL, 600, upper bound of count; requires MIN_VAL < MAX_VAL < 2^WIDTH
- STEP, 1, magnitude added or subtracted per move; requires 1 <= STEP <= MAX_VAL-MIN_VAL
- DIV, 1, number of qualifying en pulses per move; requires DIV >= 1
- WRAP, 0, 0 = saturate at bounds, 1 = wrap from one bound to the other

Ports:
- CLK  in  1  system clock, all logic on rising edge
- Rst  in  1  asynchronous, active-low reset (0 = reset)
- en  in  1  move tick, e.g. frame or ms strobe; may be tied to 1
- inc  in  1  request to increase position
- dec  in  1  request to decrease position
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current position, registered
- at_min  out  1  count == MIN_VAL
- at_max  out  1  count == MAX_VAL
- moved  out  1  one-cycle pulse, registered, high in the cycle after count changes due to inc/dec

Behaviour:
- Reset (Rst=0, asynchronous):
  - count=RESET_VAL, prescaler=0, moved=0.
  - at_min and at_max reflect RESET_VAL.
  - Release is synchronous to CLK; no move is possible in the release cycle's prior edge.
- Priority per cycle: load > dec > inc. dec wins over inc when both are high.
- Load:
  - When load=1, count <= clamp(load_val, MIN_VAL, MAX_VAL) on the next edge, with no wrap applied.
  - prescaler <= 0 and moved <= 0.
- Prescaler (width clog2(DIV), minimum 1 bit):
  - With inc|dec high, load=0 and en=1: if prescaler==DIV-1, a move fires and prescaler <= 0; otherwise prescaler increments.
  - With inc|dec high and en=0: prescaler holds.
  - With inc=dec=0: prescaler <= 0, so a new press always waits a full DIV ticks.
  - With DIV=1, a move fires on every en while a request is held. This gives the legacy behaviour when en=1.
- Move arithmetic, computed in WIDTH+1 bits to avoid overflow:
  - Decrement:
    - If count-STEP >= MIN_VAL, the result is count-STEP.
    - Otherwise the result is MIN_VAL when WRAP=0, or MAX_VAL when WRAP=1.
  - Increment:
    - If count+STEP <= MAX_VAL, the result is count+STEP.
    - Otherwise the result is MAX_VAL when WRAP=0, or MIN_VAL when WRAP=1.
  - Wrap jumps to the opposite bound exactly; the remainder is discarded.
- moved:
  - moved <= 1 only if a move fired and the new count != the old count.
  - A saturated request at a bound gives moved=0.
- at_min and at_max are combinational compares on the registered count. They never glitch relative to count.
- Reset mid-move forces reset values immediately; any pending prescaler progress is lost.
- Latency: a request to count updates in 1 cycle, plus the prescaler wait.

Decomposition:
- Shared package (game_pkg) holds:
  - screen-bound constants, e.g. CANNON_X_MIN/MAX and CANNON_X_RESET=228
  - mode constants MODE_SAT=0 and MODE_WRAP=1
- One natural sub-module: tick_prescaler. It is the en-qualified divide-by-DIV counter with clear, outputting a fire strobe. It is reusable by the alien-march and bullet timers.
- The bounded add/sub stays inline.

Test Plan:
1. Default params: assert Rst=0 mid-cycle -> count=228 immediately without a clock edge; at_min=0, at_max=0, moved=0.
2. DIV=1, en=1, inc held 3 cycles from 228 -> count 229, 230, 231; moved high for 3 cycles. Then inc=dec=1 for 1 cycle -> 230 (dec priority).
3. WRAP=0, STEP=4, load_val=2 then dec -> count=MIN_VAL=0, at_min=1. A second dec -> count stays 0, moved=0. Then load_val=2000 -> count=600, at_max=1.
4. WRAP=1, STEP=4, count=598, inc -> count=0 (MIN_VAL), moved=1. dec at 0 -> 600.
5. DIV=3, en pulsed every 4th cycle, inc held from 228 -> count changes only on the 3rd en pulse to 229. If inc drops after 2 pulses and reasserts, 3 more pulses are needed.
6. Rst asserted while prescaler=2 (DIV=3) -> after release, 3 full en pulses are needed before the first move, and count=228 until then.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for movable screen objects: cannon bounds, the
// saturate/wrap mode encodings, and the decoded move request type.
package game_pkg;

    localparam int CANNON_X_MIN   = 0;
    localparam int CANNON_X_MAX   = 600;
    localparam int CANNON_X_RESET = 228;

    localparam int MODE_SAT  = 0;
    localparam int MODE_WRAP = 1;

    // dec outranks inc, so a request is always exactly one of these
    typedef enum logic [1:0] {
        MV_NONE = 2'd0,
        MV_DEC  = 2'd1,
        MV_INC  = 2'd2
    } move_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-DIV tick qualifier. Counts en pulses while active is held and
// raises fire combinationally on the DIV-th pulse, so the consumer acts on
// that same edge. Dropping active or asserting clr restarts the count,
// which means every new request waits a full DIV ticks.
module tick_prescaler
    import game_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic Rst,
    input  logic en,
    input  logic active,
    input  logic clr,
    output logic fire
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    assign fire = active & en & ~clr & (cnt == TC);

    // Progress counter: cleared on clr or idle, advances on qualifying en
    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (clr || !active) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= fire ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pos_counter_bounded.sv
// Bounded position counter for one movable axis. Moves by STEP on prescaled
// ticks, saturating or wrapping at [MIN_VAL, MAX_VAL]; a synchronous load
// (clamped, never wrapped) overrides any move. Priority: load > dec > inc.
module pos_counter_bounded
    import game_pkg::*;
#(
    parameter int WIDTH     = 11,
    parameter int RESET_VAL = CANNON_X_RESET,
    parameter int MIN_VAL   = CANNON_X_MIN,
    parameter int MAX_VAL   = CANNON_X_MAX,
    parameter int STEP      = 1,
    parameter int DIV       = 1,
    parameter int WRAP      = MODE_SAT
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_min,
    output logic             at_max,
    output logic             moved
);

    // One extra bit so count+STEP cannot overflow before the bound compare
    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0]    MAX_X     = XW'(MAX_VAL);
    localparam logic [XW-1:0]    STEP_X    = XW'(STEP);
    localparam logic [XW-1:0]    LOW_LIM_X = XW'(MIN_VAL + STEP);
    localparam logic [WIDTH-1:0] RESET_C   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] MIN_C     = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEP_C    = WIDTH'(STEP);
    localparam bit               DO_WRAP   = (WRAP != 0);

    move_t            req;
    logic             req_any;
    logic             fire;
    logic [XW-1:0]    count_x;
    logic [XW-1:0]    inc_x;
    logic [WIDTH-1:0] move_c;
    logic [WIDTH-1:0] clamp_c;

    // Decode the request with dec taking precedence over inc
    always_comb begin
        req = MV_NONE;
        if (dec) begin
            req = MV_DEC;
        end else if (inc) begin
            req = MV_INC;
        end
    end

    assign req_any = (req != MV_NONE);

    tick_prescaler #(
        .DIV (DIV)
    ) u_tick_prescaler (
        .CLK    (CLK),
        .Rst    (Rst),
        .en     (en),
        .active (req_any),
        .clr    (load),
        .fire   (fire)
    );

    // Candidate positions: bounded step result and clamped load value.
    // On overshoot the wrap lands exactly on the opposite bound.
    always_comb begin
        count_x = {1'b0, count};
        inc_x   = count_x + STEP_X;
        move_c  = count;
        if (req == MV_DEC) begin
            if (count_x >= LOW_LIM_X) begin
                move_c = count - STEP_C;
            end else begin
                move_c = DO_WRAP ? MAX_C : MIN_C;
            end
        end else if (req == MV_INC) begin
            if (inc_x <= MAX_X) begin
                move_c = count + STEP_C;
            end else begin
                move_c = DO_WRAP ? MIN_C : MAX_C;
            end
        end

        if (load_val < MIN_C) begin
            clamp_c = MIN_C;
        end else if (load_val > MAX_C) begin
            clamp_c = MAX_C;
        end else begin
            clamp_c = load_val;
        end
    end

    // Position register and move pulse; a saturated move leaves moved low
    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            count <= RESET_C;
            moved <= 1'b0;
        end else if (load) begin
            count <= clamp_c;
            moved <= 1'b0;
        end else if (fire) begin
            count <= move_c;
            moved <= (move_c != count);
        end else begin
            moved <= 1'b0;
        end
    end

    assign at_min = (count == MIN_C);
    assign at_max = (count == MAX_C);

endmodule

// File: tb/tb_pos_counter_bounded.sv
// Bench for pos_counter_bounded: four instances cover the default build,
// saturating STEP=4, wrapping STEP=4 and DIV=3. Expected outputs are queued
// as each cycle is driven and popped for comparison after the edge.
module tb_pos_counter_bounded;

    typedef struct packed {
        logic [10:0] count;
        logic        moved;
        logic        at_min;
        logic        at_max;
    } obs_t;

    typedef struct packed {
        logic        e;
        logic        i;
        logic        d;
        logic        l;
        logic [10:0] v;
        obs_t        x;
    } step_t;

    logic        CLK = 1'b0;
    logic        Rst = 1'b0;
    logic [3:0]  en_v = '0;
    logic [3:0]  inc_v = '0;
    logic [3:0]  dec_v = '0;
    logic [3:0]  load_v = '0;
    logic [10:0] lv [4];
    logic [10:0] cnt [4];
    logic [3:0]  amin;
    logic [3:0]  amax;
    logic [3:0]  mv;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 CLK = ~CLK;

    pos_counter_bounded u0 (
        .CLK(CLK), .Rst(Rst), .en(en_v[0]), .inc(inc_v[0]), .dec(dec_v[0]),
        .load(load_v[0]), .load_val(lv[0]), .count(cnt[0]),
        .at_min(amin[0]), .at_max(amax[0]), .moved(mv[0])
    );

    pos_counter_bounded #(.STEP(4), .WRAP(0)) u1 (
        .CLK(CLK), .Rst(Rst), .en(en_v[1]), .inc(inc_v[1]), .dec(dec_v[1]),
        .load(load_v[1]), .load_val(lv[1]), .count(cnt[1]),
        .at_min(amin[1]), .at_max(amax[1]), .moved(mv[1])
    );

    pos_counter_bounded #(.STEP(4), .WRAP(1)) u2 (
        .CLK(CLK), .Rst(Rst), .en(en_v[2]), .inc(inc_v[2]), .dec(dec_v[2]),
        .load(load_v[2]), .load_val(lv[2]), .count(cnt[2]),
        .at_min(amin[2]), .at_max(amax[2]), .moved(mv[2])
    );

    pos_counter_bounded #(.DIV(3)) u3 (
        .CLK(CLK), .Rst(Rst), .en(en_v[3]), .inc(inc_v[3]), .dec(dec_v[3]),
        .load(load_v[3]), .load_val(lv[3]), .count(cnt[3]),
        .at_min(amin[3]), .at_max(amax[3]), .moved(mv[3])
    );

    function automatic obs_t get_obs(int s);
        obs_t o;
        o.count  = cnt[s];
        o.moved  = mv[s];
        o.at_min = amin[s];
        o.at_max = amax[s];
        return o;
    endfunction

    function automatic obs_t mk_obs(int c, bit m, bit mn, bit mx);
        obs_t o;
        o.count  = 11'(c);
        o.moved  = m;
        o.at_min = mn;
        o.at_max = mx;
        return o;
    endfunction

    function automatic step_t mk(bit e, bit i, bit d, bit l, int v,
                                 int c, bit m, bit mn, bit mx);
        step_t t;
        t.e = e; t.i = i; t.d = d; t.l = l;
        t.v = 11'(v);
        t.x = mk_obs(c, m, mn, mx);
        return t;
    endfunction

    // Drive one instance for one clock; the others sit idle
    task automatic drive(int s, bit e, bit i, bit d, bit l, logic [10:0] v);
        en_v = '0; inc_v = '0; dec_v = '0; load_v = '0;
        en_v[s] = e; inc_v[s] = i; dec_v[s] = d; load_v[s] = l;
        lv[s] = v;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        Rst = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        for (int s = 0; s < 4; s++) begin
            exp_q.push_back(mk_obs(228, 0, 0, 0));
            e = exp_q.pop_front(); o = get_obs(s); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_state u%0d: got cnt=%0d mv=%b min=%b max=%b want cnt=%0d mv=%b min=%b max=%b",
                         s, o.count, o.moved, o.at_min, o.at_max, e.count, e.moved, e.at_min, e.at_max);
            end
        end
        Rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk_obs(229 + k, 1, 0, 0));
            drive(0, 1, 1, 0, 0, 0);
            e = exp_q.pop_front(); o = get_obs(0); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_premove k%0d: got cnt=%0d mv=%b want cnt=%0d mv=%b",
                         k, o.count, o.moved, e.count, e.moved);
            end
        end
        // Asynchronous assert between edges: no clock edge before the check
        exp_q.push_back(mk_obs(228, 0, 0, 0));
        #3 Rst = 1'b0;
        #1;
        e = exp_q.pop_front(); o = get_obs(0); total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_async: got cnt=%0d mv=%b min=%b max=%b want cnt=%0d mv=%b min=%b max=%b",
                     o.count, o.moved, o.at_min, o.at_max, e.count, e.moved, e.at_min, e.at_max);
        end
        exp_q.push_back(mk_obs(228, 0, 0, 0));
        @(posedge CLK);
        #1 Rst = 1'b1;
        e = exp_q.pop_front(); o = get_obs(0); total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_hold: got cnt=%0d mv=%b want cnt=%0d mv=%b",
                     o.count, o.moved, e.count, e.moved);
        end
    endtask

    task automatic test_move();
        step_t tbl[6];
        obs_t  e, o;
        tbl[0] = mk(1, 1, 0, 0, 0, 229, 1, 0, 0);
        tbl[1] = mk(1, 1, 0, 0, 0, 230, 1, 0, 0);
        tbl[2] = mk(1, 1, 0, 0, 0, 231, 1, 0, 0);
        tbl[3] = mk(1, 1, 1, 0, 0, 230, 1, 0, 0);
        tbl[4] = mk(1, 0, 0, 0, 0, 230, 0, 0, 0);
        tbl[5] = mk(0, 0, 1, 0, 0, 230, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(tbl[k].x);
            drive(0, tbl[k].e, tbl[k].i, tbl[k].d, tbl[k].l, tbl[k].v);
            e = exp_q.pop_front(); o = get_obs(0); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL move k%0d: got cnt=%0d mv=%b min=%b max=%b want cnt=%0d mv=%b min=%b max=%b",
                         k, o.count, o.moved, o.at_min, o.at_max, e.count, e.moved, e.at_min, e.at_max);
            end
        end
    endtask

    task automatic test_saturate();
        step_t tbl[8];
        obs_t  e, o;
        tbl[0] = mk(1, 0, 1, 1, 2,    2,   0, 0, 0);
        tbl[1] = mk(1, 0, 1, 0, 0,    0,   1, 1, 0);
        tbl[2] = mk(1, 0, 1, 0, 0,    0,   0, 1, 0);
        tbl[3] = mk(1, 1, 0, 0, 0,    4,   1, 0, 0);
        tbl[4] = mk(1, 1, 0, 1, 2000, 600, 0, 0, 1);
        tbl[5] = mk(1, 1, 0, 0, 0,    600, 0, 0, 1);
        tbl[6] = mk(1, 0, 1, 0, 0,    596, 1, 0, 0);
        tbl[7] = mk(1, 0, 0, 0, 0,    596, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(tbl[k].x);
            drive(1, tbl[k].e, tbl[k].i, tbl[k].d, tbl[k].l, tbl[k].v);
            e = exp_q.pop_front(); o = get_obs(1); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL saturate k%0d: got cnt=%0d mv=%b min=%b max=%b want cnt=%0d mv=%b min=%b max=%b",
                         k, o.count, o.moved, o.at_min, o.at_max, e.count, e.moved, e.at_min, e.at_max);
            end
        end
    endtask

    task automatic test_wrap();
        step_t tbl[6];
        obs_t  e, o;
        tbl[0] = mk(1, 0, 0, 1, 598, 598, 0, 0, 0);
        tbl[1] = mk(1, 1, 0, 0, 0,   0,   1, 1, 0);
        tbl[2] = mk(1, 0, 1, 0, 0,   600, 1, 0, 1);
        tbl[3] = mk(1, 0, 1, 0, 0,   596, 1, 0, 0);
        tbl[4] = mk(1, 1, 0, 0, 0,   600, 1, 0, 1);
        tbl[5] = mk(1, 1, 0, 0, 0,   0,   1, 1, 0);
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(tbl[k].x);
            drive(2, tbl[k].e, tbl[k].i, tbl[k].d, tbl[k].l, tbl[k].v);
            e = exp_q.pop_front(); o = get_obs(2); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL wrap k%0d: got cnt=%0d mv=%b min=%b max=%b want cnt=%0d mv=%b min=%b max=%b",
                         k, o.count, o.moved, o.at_min, o.at_max, e.count, e.moved, e.at_min, e.at_max);
            end
        end
    endtask

    // DIV=3 instance: a move lands on every third en pulse of a held request
    task automatic test_prescale();
        obs_t e, o;
        int   base = 228;
        int   np   = 0;
        bit   en_k;
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < ((ph == 1) ? 5 : 12); k++) begin
                en_k = (k % 4 == 0);
                if (en_k) np++;
                exp_q.push_back(mk_obs(base + np / 3, en_k && (np % 3 == 0), 0, 0));
                drive(3, en_k, 1, 0, 0, 0);
                e = exp_q.pop_front(); o = get_obs(3); total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL prescale ph%0d k%0d: got cnt=%0d mv=%b want cnt=%0d mv=%b",
                             ph, k, o.count, o.moved, e.count, e.moved);
                end
            end
            base = base + np / 3;
            np = 0;
            if (ph == 1) begin
                exp_q.push_back(mk_obs(base, 0, 0, 0));
                drive(3, 1, 0, 0, 0, 0);
                e = exp_q.pop_front(); o = get_obs(3); total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL prescale_drop: got cnt=%0d mv=%b want cnt=%0d mv=%b",
                             o.count, o.moved, e.count, e.moved);
                end
            end
        end
    endtask

    // Reset with two pulses of progress banked; all of it must be lost
    task automatic test_reset_mid_prescale();
        obs_t e, o;
        bit   en_k;
        int   np = 0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(mk_obs(230, 0, 0, 0));
            drive(3, (k % 4 == 0), 1, 0, 0, 0);
            e = exp_q.pop_front(); o = get_obs(3); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rstmid_pre k%0d: got cnt=%0d mv=%b want cnt=%0d mv=%b",
                         k, o.count, o.moved, e.count, e.moved);
            end
        end
        exp_q.push_back(mk_obs(228, 0, 0, 0));
        #3 Rst = 1'b0;
        #1;
        e = exp_q.pop_front(); o = get_obs(3); total++;
        if (o !== e) begin
            bad++;
            $display("FAIL rstmid_async: got cnt=%0d mv=%b want cnt=%0d mv=%b",
                     o.count, o.moved, e.count, e.moved);
        end
        @(posedge CLK);
        #1 Rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            en_k = (k % 4 == 0);
            if (en_k) np++;
            exp_q.push_back(mk_obs((np >= 3) ? 229 : 228, en_k && (np == 3), 0, 0));
            drive(3, en_k, 1, 0, 0, 0);
            e = exp_q.pop_front(); o = get_obs(3); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rstmid_post k%0d: got cnt=%0d mv=%b want cnt=%0d mv=%b",
                         k, o.count, o.moved, e.count, e.moved);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++) lv[s] = '0;
        test_reset();
        test_move();
        test_saturate();
        test_wrap();
        test_prescale();
        test_reset_mid_prescale();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
